sipo_frame_controller: RTL and testbench

Frame-level controller for the serial-in/parallel-out capture path. The block waits for a frame start and clocks exactly WORD_WIDTH serial bits into its shift register. It then hands the assembled word to the downstream consumer through a one-entry valid/ready buffer, and flags any word lost to back-pressure. It sits between a serial line receiver and the parallel bus logic, on the same falling-edge clock domain as the shift registers.

---
 rtl/sipo_frame_controller.sv | 116 +++++++++++
 tb/tb_sipo_frame_controller.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/sipo_frame_controller.sv
// Frame-level controller for the serial capture path: counts WORD_WIDTH bits into a
// shift register on the falling edge and presents each word through a one-entry valid/ready buffer.
module sipo_frame_controller #(
    parameter int WORD_WIDTH = 32
) (
    input  logic                          Clk_In,
    input  logic                          Reset_In,
    input  logic                          Start_In,
    input  logic                          Abort_In,
    input  logic                          Serial_Data_In,
    input  logic                          Ready_In,
    input  logic                          Clear_Overrun_In,
    output logic                          Busy_Out,
    output logic [$clog2(WORD_WIDTH):0]   Bit_Count_Out,
    output logic [WORD_WIDTH-1:0]         Data_Out,
    output logic                          Valid_Out,
    output logic                          Overrun_Out
);

    localparam int CW = $clog2(WORD_WIDTH) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WORD_WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t                  state_reg, state_next;
    // The oldest bit leaves the register on the final edge, so only WORD_WIDTH-1 bits need storage.
    logic [WORD_WIDTH-2:0]   shift_reg, shift_next;
    logic [CW-1:0]           count_reg, count_next;
    logic [WORD_WIDTH-1:0]   data_reg, data_next;
    logic                    valid_reg, valid_next;
    logic                    overrun_reg, overrun_next;
    logic                    load_word;
    logic [WORD_WIDTH-1:0]   shifted_word;

    assign shifted_word = {Serial_Data_In, shift_reg};

    always_ff @(negedge Clk_In or posedge Reset_In) begin
        if (Reset_In) begin
            state_reg   <= IDLE;
            shift_reg   <= '0;
            count_reg   <= '0;
            data_reg    <= '0;
            valid_reg   <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            shift_reg   <= shift_next;
            count_reg   <= count_next;
            data_reg    <= data_next;
            valid_reg   <= valid_next;
            overrun_reg <= overrun_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        shift_next   = shift_reg;
        count_next   = count_reg;
        data_next    = data_reg;
        valid_next   = valid_reg;
        overrun_next = overrun_reg;
        load_word    = 1'b0;

        case (state_reg)
            IDLE: begin
                if (Start_In) begin
                    state_next = SHIFT;
                    count_next = '0;
                end
            end
            SHIFT: begin
                if (Abort_In) begin
                    state_next = IDLE;
                    count_next = '0;
                end else begin
                    shift_next = shifted_word[WORD_WIDTH-1:1];
                    if (count_reg == LAST_BIT) begin
                        load_word  = 1'b1;
                        count_next = '0;
                        state_next = Start_In ? SHIFT : IDLE;
                    end else begin
                        count_next = count_reg + CW'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
                count_next = '0;
            end
        endcase

        // A fresh word always wins the buffer; a transfer only matters when nothing new arrives.
        if (load_word) begin
            data_next  = shifted_word;
            valid_next = 1'b1;
        end else if (valid_reg && Ready_In) begin
            valid_next = 1'b0;
        end

        if (load_word && valid_reg && !Ready_In) begin
            overrun_next = 1'b1;
        end else if (Clear_Overrun_In) begin
            overrun_next = 1'b0;
        end
    end

    assign Busy_Out      = (state_reg == SHIFT);
    assign Bit_Count_Out = count_reg;
    assign Data_Out      = data_reg;
    assign Valid_Out     = valid_reg;
    assign Overrun_Out   = overrun_reg;

endmodule

// File: tb/tb_sipo_frame_controller.sv
// Directed bench for sipo_frame_controller: inputs change after the rising edge, outputs
// are sampled after the rising edge, the DUT acts on the falling edge in between.
module tb_sipo_frame_controller;

    localparam int W = 32;

    logic          Clk_In = 1'b0;
    logic          Reset_In;
    logic          Start_In;
    logic          Abort_In;
    logic          Serial_Data_In;
    logic          Ready_In;
    logic          Clear_Overrun_In;
    logic          Busy_Out;
    logic [5:0]    Bit_Count_Out;
    logic [W-1:0]  Data_Out;
    logic          Valid_Out;
    logic          Overrun_Out;

    int check_count = 0;
    int pass_count  = 0;
    int busy_low    = 0;
    int early_valid = 0;

    sipo_frame_controller #(.WORD_WIDTH(W)) dut (
        .Clk_In           (Clk_In),
        .Reset_In         (Reset_In),
        .Start_In         (Start_In),
        .Abort_In         (Abort_In),
        .Serial_Data_In   (Serial_Data_In),
        .Ready_In         (Ready_In),
        .Clear_Overrun_In (Clear_Overrun_In),
        .Busy_Out         (Busy_Out),
        .Bit_Count_Out    (Bit_Count_Out),
        .Data_Out         (Data_Out),
        .Valid_Out        (Valid_Out),
        .Overrun_Out      (Overrun_Out)
    );

    always #5 Clk_In = ~Clk_In;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        check_count++;
        if (observed === expected) begin
            pass_count++;
            $display("check %s: got %0h", tag, observed);
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One falling edge for the DUT, then return just after the following rising edge.
    task automatic step();
        @(negedge Clk_In);
        @(posedge Clk_In);
        #1;
    endtask

    task automatic start_frame();
        Start_In = 1'b1;
        step();
        Start_In = 1'b0;
    endtask

    // Shift n bits of w LSB first; Start_In/Ready_In take the given values on the last edge.
    task automatic shift_bits(input logic [W-1:0] w, input int n, input logic start_last, input logic rdy_last);
        for (int i = 0; i < n; i++) begin
            Serial_Data_In = w[i];
            if (i == n - 1) begin
                Start_In = start_last;
                Ready_In = rdy_last;
            end
            step();
            Start_In = 1'b0;
            if (i < n - 1) begin
                if (!Busy_Out) busy_low++;
                if (Valid_Out) early_valid++;
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},    64'(Busy_Out),      64'd0);
        check({tag, "_count"},   64'(Bit_Count_Out), 64'd0);
        check({tag, "_data"},    64'(Data_Out),      64'd0);
        check({tag, "_valid"},   64'(Valid_Out),     64'd0);
        check({tag, "_overrun"}, 64'(Overrun_Out),   64'd0);
    endtask

    initial begin
        Reset_In = 1'b1;
        Start_In = 1'b0;
        Abort_In = 1'b0;
        Serial_Data_In = 1'b0;
        Ready_In = 1'b0;
        Clear_Overrun_In = 1'b0;
        step();
        step();
        check_all_zero("reset");
        Reset_In = 1'b0;

        // Single frame
        Ready_In = 1'b1;
        start_frame();
        check("single_busy_start", 64'(Busy_Out), 64'd1);
        busy_low = 0; early_valid = 0;
        shift_bits(32'hA5A5_1234, W, 1'b0, 1'b1);
        check("single_busy_edges", 64'(busy_low), 64'd0);
        check("single_no_early_valid", 64'(early_valid), 64'd0);
        check("single_valid", 64'(Valid_Out), 64'd1);
        check("single_data", 64'(Data_Out), 64'hA5A5_1234);
        check("single_busy_end", 64'(Busy_Out), 64'd0);
        check("single_overrun", 64'(Overrun_Out), 64'd0);
        step();
        check("single_valid_pulse", 64'(Valid_Out), 64'd0);

        // Back-to-back with Start_In on the final edge
        start_frame();
        busy_low = 0; early_valid = 0;
        shift_bits(32'hFFFF_0000, W, 1'b1, 1'b1);
        check("b2b_valid1", 64'(Valid_Out), 64'd1);
        check("b2b_data1", 64'(Data_Out), 64'hFFFF_0000);
        check("b2b_busy_kept", 64'(Busy_Out), 64'd1);
        check("b2b_count_restart", 64'(Bit_Count_Out), 64'd0);
        shift_bits(32'h0000_FFFF, W, 1'b0, 1'b1);
        check("b2b_busy_never_low", 64'(busy_low), 64'd0);
        check("b2b_single_pulse", 64'(early_valid), 64'd0);
        check("b2b_valid2", 64'(Valid_Out), 64'd1);
        check("b2b_data2", 64'(Data_Out), 64'h0000_FFFF);
        step();

        // Back-pressure and overrun
        Ready_In = 1'b0;
        start_frame();
        shift_bits(32'h1111_1111, W, 1'b1, 1'b0);
        check("bp_data1", 64'(Data_Out), 64'h1111_1111);
        check("bp_overrun1", 64'(Overrun_Out), 64'd0);
        shift_bits(32'h2222_2222, W, 1'b0, 1'b0);
        check("bp_data2", 64'(Data_Out), 64'h2222_2222);
        check("bp_overrun2", 64'(Overrun_Out), 64'd1);
        check("bp_valid2", 64'(Valid_Out), 64'd1);
        Clear_Overrun_In = 1'b1;
        step();
        Clear_Overrun_In = 1'b0;
        check("bp_overrun_clear", 64'(Overrun_Out), 64'd0);
        check("bp_valid_held", 64'(Valid_Out), 64'd1);
        Ready_In = 1'b1;
        step();
        check("bp_valid_drain", 64'(Valid_Out), 64'd0);

        // Load coinciding with a transfer
        Ready_In = 1'b0;
        start_frame();
        shift_bits(32'h3333_3333, W, 1'b1, 1'b0);
        shift_bits(32'h4444_4444, W, 1'b0, 1'b1);
        check("sim_valid", 64'(Valid_Out), 64'd1);
        check("sim_data", 64'(Data_Out), 64'h4444_4444);
        check("sim_overrun", 64'(Overrun_Out), 64'd0);
        step();
        check("sim_valid_drain", 64'(Valid_Out), 64'd0);

        // Abort after 10 bits, then a full frame
        start_frame();
        shift_bits(32'h0F0F_0F0F, 10, 1'b0, 1'b1);
        check("abort_count10", 64'(Bit_Count_Out), 64'd10);
        Abort_In = 1'b1;
        step();
        Abort_In = 1'b0;
        check("abort_busy", 64'(Busy_Out), 64'd0);
        check("abort_count", 64'(Bit_Count_Out), 64'd0);
        check("abort_valid", 64'(Valid_Out), 64'd0);
        check("abort_data_kept", 64'(Data_Out), 64'h4444_4444);
        start_frame();
        shift_bits(32'hDEAD_BEEF, W, 1'b0, 1'b1);
        check("abort_next_valid", 64'(Valid_Out), 64'd1);
        check("abort_next_data", 64'(Data_Out), 64'hDEAD_BEEF);
        step();

        // Abort on the final edge loses the word
        start_frame();
        shift_bits(32'h1234_5678, W - 1, 1'b0, 1'b1);
        Serial_Data_In = 1'b1;
        Abort_In = 1'b1;
        step();
        Abort_In = 1'b0;
        check("abort_last_valid", 64'(Valid_Out), 64'd0);
        check("abort_last_data", 64'(Data_Out), 64'hDEAD_BEEF);
        check("abort_last_busy", 64'(Busy_Out), 64'd0);

        // Asynchronous reset between edges, mid-frame at bit 17
        start_frame();
        shift_bits(32'hCAFE_F00D, 17, 1'b0, 1'b1);
        #2 Reset_In = 1'b1;
        #1;
        check_all_zero("async_reset");
        step();
        Reset_In = 1'b0;
        start_frame();
        shift_bits(32'h8000_0001, W, 1'b0, 1'b1);
        check("post_reset_valid", 64'(Valid_Out), 64'd1);
        check("post_reset_data", 64'(Data_Out), 64'h8000_0001);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
